// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared phase/state encodings and the phase-to-{in1,in2} pattern map
package hbridge_pkg;
  typedef enum logic [1:0] {PH_COAST = 2'd0, PH_FWD = 2'd1, PH_REV = 2'd2, PH_BRAKE = 2'd3} phase_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
  localparam logic [1:0] PAT_COAST = 2'b00;
  localparam logic [1:0] PAT_FWD   = 2'b10;
  localparam logic [1:0] PAT_REV   = 2'b01;
  localparam logic [1:0] PAT_BRAKE = 2'b11;
  function automatic logic [1:0] ph_bits(phase_t p);
    return p == PH_FWD ? PAT_FWD : p == PH_REV ? PAT_REV : p == PH_BRAKE ? PAT_BRAKE : PAT_COAST;
  endfunction
endpackage

// File: rtl/hbridge_stim_seq_if.sv
// hbridge_stim_seq_if: control inputs (start/abort/dwell/loops/pwm_en/duty/ch_mask) and bridge outputs (in1/in2/phase/busy/done)
interface hbridge_stim_seq_if #(parameter int N_CH = 2, parameter int CNT_W = 16, parameter int PWM_W = 8);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] loops;
  logic             pwm_en;
  logic [PWM_W-1:0] duty;
  logic [N_CH-1:0]  ch_mask;
  logic [N_CH-1:0]  in1;
  logic [N_CH-1:0]  in2;
  logic [1:0]       phase;
  logic             busy;
  logic             done;
  modport master (output start, abort, dwell, loops, pwm_en, duty, ch_mask, input in1, in2, phase, busy, done);
  modport slave  (input start, abort, dwell, loops, pwm_en, duty, ch_mask, output in1, in2, phase, busy, done);
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM counter (clr zeroes, run advances); hi_nxt is the compare for the count about to be loaded
module pwm_gen #(parameter int PWM_W = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [PWM_W-1:0] duty,
  output logic             hi_nxt
);
  logic [PWM_W-1:0] cnt, cnt_n;
  assign cnt_n  = clr ? '0 : run ? cnt + PWM_W'(1) : cnt;
  assign hi_nxt = cnt_n < duty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_n;
endmodule

// File: rtl/hbridge_stim_seq.sv
// hbridge_stim_seq: COAST->FWD->(DEAD)->REV->BRAKE stimulus sequencer; clk, rst_n (async active-low), bus = control in / per-channel in1,in2, phase, busy, done out
module hbridge_stim_seq
  import hbridge_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 16,
  parameter int PWM_W    = 8,
  parameter int DEAD_CYC = 4
) (
  input logic clk,
  input logic rst_n,
  hbridge_stim_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC > 0 ? DEAD_CYC - 1 : 0);
  state_t st, st_n;
  phase_t ph, ph_n;
  logic [CNT_W-1:0] dcnt, dcnt_n, lcnt, lcnt_n, lcnt_inc, dlast, loops_r;
  logic [1:0] pat, pat_n;
  logic done_r, done_n, clr, hi_nxt, chop;
  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .run    (st != ST_IDLE),
    .duty   (bus.duty),
    .hi_nxt (hi_nxt)
  );
  assign lcnt_inc = lcnt + CNT_W'(1);
  assign chop     = bus.pwm_en && (ph_n == PH_FWD || ph_n == PH_REV) && !hi_nxt;
  assign pat_n    = (st_n == ST_RUN && !chop) ? ph_bits(ph_n) : PAT_COAST;
  always_comb begin
    st_n   = st;
    ph_n   = ph;
    dcnt_n = dcnt;
    lcnt_n = lcnt;
    done_n = 1'b0;
    clr    = 1'b0;
    if (st == ST_IDLE) begin
      if (bus.start && !bus.abort) begin
        st_n   = ST_RUN;
        ph_n   = PH_COAST;
        dcnt_n = '0;
        lcnt_n = '0;
        clr    = 1'b1;
      end
    end else if (bus.abort) begin
      st_n   = ST_IDLE;
      ph_n   = PH_COAST;
      dcnt_n = '0;
      done_n = 1'b1;
    end else if (st == ST_DEAD) begin
      dcnt_n = dcnt == DEAD_LAST ? '0 : dcnt + CNT_W'(1);
      st_n   = dcnt == DEAD_LAST ? ST_RUN : ST_DEAD;
      ph_n   = dcnt == DEAD_LAST ? PH_REV : PH_COAST;
    end else if (dcnt != dlast) begin
      dcnt_n = dcnt + CNT_W'(1);
    end else begin
      dcnt_n = '0;
      if (ph == PH_FWD && DEAD_CYC > 0) begin
        st_n = ST_DEAD;
        ph_n = PH_COAST;
      end else if (ph == PH_BRAKE) begin
        lcnt_n = lcnt_inc;
        ph_n   = PH_COAST;
        if (loops_r != '0 && lcnt_inc == loops_r) begin
          st_n   = ST_IDLE;
          done_n = 1'b1;
        end
      end else begin
        ph_n = phase_t'(ph + 2'd1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= ST_IDLE;
      ph      <= PH_COAST;
      dcnt    <= '0;
      lcnt    <= '0;
      dlast   <= '0;
      loops_r <= '0;
      pat     <= PAT_COAST;
      done_r  <= 1'b0;
    end else begin
      st     <= st_n;
      ph     <= ph_n;
      dcnt   <= dcnt_n;
      lcnt   <= lcnt_n;
      pat    <= pat_n;
      done_r <= done_n;
      if (clr) begin
        dlast   <= bus.dwell == '0 ? '0 : bus.dwell - CNT_W'(1);
        loops_r <= bus.loops;
      end
    end
  assign bus.phase = ph;
  assign bus.busy  = st != ST_IDLE;
  assign bus.done  = done_r;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign bus.in1[c] = pat[1] & bus.ch_mask[c];
    assign bus.in2[c] = pat[0] & bus.ch_mask[c];
  end
endmodule

// File: doc/hbridge_stim_seq.md
HBRIDGE_STIM_SEQ -- requirements
Module: hbridge_stim_seq

Interface
REQ-001 The block SHALL have these parameters:
- N_CH, default 2, number of H-bridge channels driven.
- CNT_W, default 16, width of the dwell and loop counters.
- PWM_W, default 8, width of the PWM counter and duty.
- DEAD_CYC, default 4, coast cycles inserted on a FWD->REV change; legal range 0..255.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a sequence from IDLE.
- abort  in  1  level; forces the sequence to stop.
- dwell  in  CNT_W  cycles each phase is held; 0 is treated as 1.
- loops  in  CNT_W  number of full sequences to run; 0 means run until abort.
- pwm_en  in  1  when set, the FWD and REV phases are PWM-chopped.
- duty  in  PWM_W  PWM high count per period.
- ch_mask  in  N_CH  per-channel enable; a masked channel drives 00.
- in1  out  N_CH  IN1 drive, one bit per channel.
- in2  out  N_CH  IN2 drive, one bit per channel.
- phase  out  2  current phase: 0=COAST, 1=FWD, 2=REV, 3=BRAKE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence ends.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RUN and DEAD.
REQ-004 Phase order SHALL be COAST -> FWD -> REV -> BRAKE -> COAST, which is one loop.
REQ-005 Phase bit patterns SHALL be: COAST {in1,in2}=00, FWD=10, REV=01, BRAKE=11.
REQ-006 In IDLE, a start pulse SHALL move the FSM to RUN, phase COAST, with busy high on the next cycle.
REQ-007 start SHALL be ignored while busy is high.
REQ-008 Each phase SHALL last exactly max(dwell,1) cycles.
REQ-009 dwell and loops SHALL be sampled at start; later changes to them SHALL have no effect until the next start.
REQ-010 On a FWD->REV change with DEAD_CYC>0, the FSM SHALL enter DEAD and hold COAST (00) for exactly DEAD_CYC cycles before REV begins; the phase output SHALL read 0 during DEAD.
REQ-011 With DEAD_CYC=0, REV SHALL follow FWD directly.
REQ-012 After BRAKE completes, the loop counter SHALL increment.
REQ-013 If loops is nonzero and the loop counter equals loops, the FSM SHALL go to IDLE and pulse done; otherwise it SHALL continue from COAST.
REQ-014 The loop counter SHALL wrap modulo 2^CNT_W when loops=0.
REQ-015 A free-running PWM counter of PWM_W bits SHALL run continuously while busy and SHALL clear to 0 on start.
REQ-016 With pwm_en=1 in FWD or REV, the active bit SHALL be 1 when pwm_cnt < duty and 0 otherwise. duty=0 gives constant 0; duty=2^PWM_W-1 gives 2^PWM_W-1 high cycles per 2^PWM_W.
REQ-017 BRAKE and COAST SHALL be unaffected by pwm_en.
REQ-018 Channel c SHALL output the phase pattern AND ch_mask[c]; ch_mask SHALL be applied combinationally from the registered phase.
REQ-019 in1, in2 and phase SHALL be registered.
REQ-020 An abort asserted in any non-IDLE state SHALL force outputs to 00 and the state to IDLE on the next edge, and pulse done once.
REQ-021 When abort and start coincide in IDLE, abort SHALL win and the FSM SHALL stay in IDLE with no done pulse.
REQ-022 When abort coincides with the final BRAKE cycle, exactly one done pulse SHALL be produced.
REQ-023 in1 and in2 of one channel SHALL never change 10->01 or 01->10 in a single cycle when DEAD_CYC>0.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with in1=0, in2=0, phase=0, busy=0, done=0, and all counters cleared; this SHALL hold asynchronously.
REQ-025 Reset de-assertion SHALL be synchronised externally; the block SHALL resume from IDLE only.
REQ-026 A reset taken mid-sequence SHALL drop the outputs to 00 immediately, without waiting for a clock edge.

Structure
REQ-027 The phase encodings, FSM state encodings and bit patterns SHALL live in the shared package hbridge_pkg.
REQ-028 The PWM generator (counter and compare) SHALL be a separate sub-module, pwm_gen, parameterised by PWM_W.
REQ-029 Per-channel masking SHALL be a generate loop over N_CH inside hbridge_stim_seq.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Basic sequence: dwell=100, loops=1, pwm_en=0, mask=11 -> 00,10,00(x4 dead),01,11 with each non-dead phase 100 cycles, then done pulse, busy falls.
- PWM: pwm_en=1, duty=64, PWM_W=8 -> in FWD, in1 high 64 of every 256 cycles; in2 = 0.
- Dead-time: DEAD_CYC=4 -> exactly 4 cycles of 00 between the last 10 and the first 01; no direct 10->01 step on any channel.
- Abort: abort during REV at cycle 50 -> 00 on the next edge, one done pulse, busy=0.
- Edge cases: dwell=0 gives 1-cycle phases; loops=0 runs for more than 3 loops until abort; ch_mask=01 keeps channel 1 at 00 throughout.
- Async reset: rst_n low mid-FWD -> outputs 00 before the next clk edge; start after release replays from COAST.
